id_ex_issue: RTL and testbench

- Decode-to-execute pipeline register that directly feeds the 32-bit ALU (A, B, 4-bit ALUOp, Result, Zero).
- Captures decoded RV32I fields and translates opcode/funct3/funct7[5] into the ALU's ALUOp encoding.
- Resolves operand forwarding from the MEM and WB stages and selects ALU A/B sources.
- Provides a valid/ready handshake with flush support.

---
 rtl/id_ex_issue.sv | 266 ++++++++++++++++++++++++++
 tb/tb_id_ex_issue.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_issue.sv
// Decode-to-execute issue register: decodes RV32I ALU controls, forwards operands.
// Ports: in_valid/in_ready + decoded fields in, ex_valid/ex_ready + ALU A/B/op out.

package id_ex_pkg;

  typedef enum logic [1:0] {
    A_RS1,
    A_PC,
    A_ZERO
  } a_sel_e;

  typedef enum logic [1:0] {
    B_RS2,
    B_IMM,
    B_FOUR,
    B_ZERO
  } b_sel_e;

  typedef struct packed {
    a_sel_e     a_sel;
    b_sel_e     b_sel;
    logic [3:0] op;
    logic       illegal;
  } id_ex_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;

endpackage

module id_ex_issue
  import id_ex_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic [REGW-1:0] rs1_idx,
  input  logic [REGW-1:0] rs2_idx,
  input  logic [REGW-1:0] rd_idx,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  input  logic            flush,
  input  logic            mem_fwd_valid,
  input  logic [REGW-1:0] mem_fwd_rd,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic            wb_fwd_valid,
  input  logic [REGW-1:0] wb_fwd_rd,
  input  logic [XLEN-1:0] wb_fwd_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  output logic [REGW-1:0] ex_rd,
  output logic [XLEN-1:0] ex_store_data,
  output logic [XLEN-1:0] ex_pc,
  output logic            illegal
);

  function automatic logic [3:0] f_map(
    input logic [2:0] f3,
    input logic       alt,
    input logic       is_r
  );
    logic [3:0] op;
    op = 4'b0000;
    unique case (f3)
      3'b000: op = (is_r && alt) ? 4'b0001 : 4'b0000;
      3'b001: op = 4'b0101;
      3'b010: op = 4'b1000;
      3'b011: op = 4'b1001;
      3'b100: op = 4'b0100;
      3'b101: op = alt ? 4'b0111 : 4'b0110;
      3'b110: op = 4'b0011;
      3'b111: op = 4'b0010;
      default: op = 4'b0000;
    endcase
    return op;
  endfunction

  function automatic logic hit(
    input logic            v,
    input logic [REGW-1:0] rd,
    input logic [REGW-1:0] idx
  );
    return v && (rd == idx) && (idx != '0);
  endfunction

  logic            r_valid;
  id_ex_t          r_ctl;
  id_ex_t          dec;
  logic [REGW-1:0] r_rs1_idx;
  logic [REGW-1:0] r_rs2_idx;
  logic [XLEN-1:0] r_rs1_val;
  logic [XLEN-1:0] r_rs2_val;
  logic [XLEN-1:0] r_imm;
  logic [XLEN-1:0] r_pc;
  logic [REGW-1:0] r_rd;

  logic [XLEN-1:0] cap_rs1;
  logic [XLEN-1:0] cap_rs2;
  logic [XLEN-1:0] hold_rs1;
  logic [XLEN-1:0] hold_rs2;
  logic            capture;
  logic            stall;

  assign in_ready = !r_valid || ex_ready;
  assign capture  = in_valid && in_ready && !flush;
  assign stall    = r_valid && !ex_ready;

  always_comb begin
    dec         = '0;
    dec.a_sel   = A_RS1;
    dec.b_sel   = B_RS2;
    dec.op      = 4'b0000;
    dec.illegal = 1'b0;
    unique case (1'b1)
      (opcode == OP_R): begin
        dec.op = f_map(funct3, funct7_5, 1'b1);
      end
      (opcode == OP_I): begin
        dec.b_sel = B_IMM;
        dec.op    = f_map(funct3, funct7_5, 1'b0);
      end
      (opcode == OP_LD),
      (opcode == OP_ST): begin
        dec.b_sel = B_IMM;
      end
      (opcode == OP_LUI): begin
        dec.a_sel = A_ZERO;
        dec.b_sel = B_IMM;
      end
      (opcode == OP_AUIPC): begin
        dec.a_sel = A_PC;
        dec.b_sel = B_IMM;
      end
      (opcode == OP_JAL),
      (opcode == OP_JALR): begin
        dec.a_sel = A_PC;
        dec.b_sel = B_FOUR;
      end
      (opcode == OP_BR): begin
        unique case (funct3[2:1])
          2'b00:   dec.op = 4'b0001;
          2'b10:   dec.op = 4'b1000;
          2'b11:   dec.op = 4'b1001;
          default: dec.illegal = 1'b1;
        endcase
      end
      default: begin
        dec.a_sel   = A_ZERO;
        dec.b_sel   = B_ZERO;
        dec.illegal = 1'b1;
      end
    endcase
  end

  // MEM is younger than WB, so it wins when both target the same register.
  always_comb begin
    cap_rs1 = rs1_data;
    if (rs1_idx == '0)
      cap_rs1 = '0;
    else if (hit(mem_fwd_valid, mem_fwd_rd, rs1_idx))
      cap_rs1 = mem_fwd_data;
    else if (hit(wb_fwd_valid, wb_fwd_rd, rs1_idx))
      cap_rs1 = wb_fwd_data;

    cap_rs2 = rs2_data;
    if (rs2_idx == '0)
      cap_rs2 = '0;
    else if (hit(mem_fwd_valid, mem_fwd_rd, rs2_idx))
      cap_rs2 = mem_fwd_data;
    else if (hit(wb_fwd_valid, wb_fwd_rd, rs2_idx))
      cap_rs2 = wb_fwd_data;
  end

  // A stalled operand may still be waiting on a producer; keep it
  // unless a writer for its register shows up.
  always_comb begin
    hold_rs1 = r_rs1_val;
    if (hit(mem_fwd_valid, mem_fwd_rd, r_rs1_idx))
      hold_rs1 = mem_fwd_data;
    else if (hit(wb_fwd_valid, wb_fwd_rd, r_rs1_idx))
      hold_rs1 = wb_fwd_data;

    hold_rs2 = r_rs2_val;
    if (hit(mem_fwd_valid, mem_fwd_rd, r_rs2_idx))
      hold_rs2 = mem_fwd_data;
    else if (hit(wb_fwd_valid, wb_fwd_rd, r_rs2_idx))
      hold_rs2 = wb_fwd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_ctl     <= '0;
      r_rs1_idx <= '0;
      r_rs2_idx <= '0;
      r_rs1_val <= '0;
      r_rs2_val <= '0;
      r_imm     <= '0;
      r_pc      <= '0;
      r_rd      <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (capture) begin
      r_valid   <= 1'b1;
      r_ctl     <= dec;
      r_rs1_idx <= rs1_idx;
      r_rs2_idx <= rs2_idx;
      r_rs1_val <= cap_rs1;
      r_rs2_val <= cap_rs2;
      r_imm     <= imm;
      r_pc      <= pc;
      r_rd      <= rd_idx;
    end else if (r_valid && ex_ready) begin
      r_valid <= 1'b0;
    end else if (stall) begin
      r_rs1_val <= hold_rs1;
      r_rs2_val <= hold_rs2;
    end
  end

  always_comb begin
    alu_a = '0;
    unique case (r_ctl.a_sel)
      A_RS1:   alu_a = r_rs1_val;
      A_PC:    alu_a = r_pc;
      default: alu_a = '0;
    endcase
  end

  always_comb begin
    alu_b = '0;
    unique case (r_ctl.b_sel)
      B_RS2:   alu_b = r_rs2_val;
      B_IMM:   alu_b = r_imm;
      B_FOUR:  alu_b = XLEN'(4);
      default: alu_b = '0;
    endcase
  end

  assign ex_valid      = r_valid;
  assign alu_op        = r_ctl.op;
  assign illegal       = r_ctl.illegal;
  assign ex_rd         = r_rd;
  assign ex_store_data = r_rs2_val;
  assign ex_pc         = r_pc;

endmodule

// File: tb/tb_id_ex_issue.sv
// Directed bench for id_ex_issue: decode, forwarding, stall, flush, reset.
// Expected values are hand-computed constants.

module tb_id_ex_issue;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [4:0]  rd_idx;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic [31:0] pc;
  logic        flush;
  logic        mem_fwd_valid;
  logic [4:0]  mem_fwd_rd;
  logic [31:0] mem_fwd_data;
  logic        wb_fwd_valid;
  logic [4:0]  wb_fwd_rd;
  logic [31:0] wb_fwd_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [4:0]  ex_rd;
  logic [31:0] ex_store_data;
  logic [31:0] ex_pc;
  logic        illegal;

  int n_cmp;
  int n_err;

  id_ex_issue #(.XLEN(32), .REGW(5)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .opcode(opcode),
    .funct3(funct3),
    .funct7_5(funct7_5),
    .rs1_idx(rs1_idx),
    .rs2_idx(rs2_idx),
    .rd_idx(rd_idx),
    .rs1_data(rs1_data),
    .rs2_data(rs2_data),
    .imm(imm),
    .pc(pc),
    .flush(flush),
    .mem_fwd_valid(mem_fwd_valid),
    .mem_fwd_rd(mem_fwd_rd),
    .mem_fwd_data(mem_fwd_data),
    .wb_fwd_valid(wb_fwd_valid),
    .wb_fwd_rd(wb_fwd_rd),
    .wb_fwd_data(wb_fwd_data),
    .ex_valid(ex_valid),
    .ex_ready(ex_ready),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_op(alu_op),
    .ex_rd(ex_rd),
    .ex_store_data(ex_store_data),
    .ex_pc(ex_pc),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(
    input logic [6:0]  op,
    input logic [2:0]  f3,
    input logic        f7,
    input logic [4:0]  r1,
    input logic [4:0]  r2,
    input logic [4:0]  rd,
    input logic [31:0] d1,
    input logic [31:0] d2,
    input logic [31:0] im,
    input logic [31:0] p
  );
    opcode   = op;
    funct3   = f3;
    funct7_5 = f7;
    rs1_idx  = r1;
    rs2_idx  = r2;
    rd_idx   = rd;
    rs1_data = d1;
    rs2_data = d2;
    imm      = im;
    pc       = p;
    in_valid = 1'b1;
  endtask

  task automatic issue(
    input logic [6:0]  op,
    input logic [2:0]  f3,
    input logic        f7,
    input logic [4:0]  r1,
    input logic [4:0]  r2,
    input logic [4:0]  rd,
    input logic [31:0] d1,
    input logic [31:0] d2,
    input logic [31:0] im,
    input logic [31:0] p
  );
    set_in(op, f3, f7, r1, r2, rd, d1, d2, im, p);
    step();
    in_valid = 1'b0;
  endtask

  task automatic clr_fwd();
    mem_fwd_valid = 1'b0;
    mem_fwd_rd    = '0;
    mem_fwd_data  = '0;
    wb_fwd_valid  = 1'b0;
    wb_fwd_rd     = '0;
    wb_fwd_data   = '0;
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b0;
    ex_ready = 1'b1;
    opcode   = '0;
    funct3   = '0;
    funct7_5 = 1'b0;
    rs1_idx  = '0;
    rs2_idx  = '0;
    rd_idx   = '0;
    rs1_data = '0;
    rs2_data = '0;
    imm      = '0;
    pc       = '0;
    clr_fwd();
    step();
    step();

    check("rst_valid", 32'(ex_valid), 32'd0);
    check("rst_a", alu_a, 32'd0);
    check("rst_b", alu_b, 32'd0);
    check("rst_op", 32'(alu_op), 32'd0);
    check("rst_rd", 32'(ex_rd), 32'd0);
    check("rst_sd", ex_store_data, 32'd0);
    check("rst_pc", ex_pc, 32'd0);
    check("rst_ill", 32'(illegal), 32'd0);
    check("rst_rdy", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    step();

    // add x3, x1, x2
    issue(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3,
          32'd5, 32'd7, 32'd0, 32'h40);
    check("add_valid", 32'(ex_valid), 32'd1);
    check("add_a", alu_a, 32'd5);
    check("add_b", alu_b, 32'd7);
    check("add_op", 32'(alu_op), 32'd0);
    check("add_rdy", 32'(in_ready), 32'd1);
    check("add_rd", 32'(ex_rd), 32'd3);
    check("add_sd", ex_store_data, 32'd7);
    check("add_pc", ex_pc, 32'h40);
    step();
    check("bubble", 32'(ex_valid), 32'd0);

    issue(7'b0110011, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3,
          32'd9, 32'd4, 32'd0, 32'h0);
    check("sub_op", 32'(alu_op), 32'h1);
    issue(7'b0010011, 3'b101, 1'b1, 5'd1, 5'd0, 5'd3,
          32'd9, 32'd4, 32'd3, 32'h0);
    check("srai_op", 32'(alu_op), 32'h7);
    check("srai_b", alu_b, 32'd3);
    check("srai_a", alu_a, 32'd9);
    issue(7'b0010011, 3'b101, 1'b0, 5'd1, 5'd0, 5'd3,
          32'd9, 32'd4, 32'd3, 32'h0);
    check("srli_op", 32'(alu_op), 32'h6);
    issue(7'b0010011, 3'b000, 1'b1, 5'd1, 5'd0, 5'd3,
          32'd9, 32'd4, 32'd3, 32'h0);
    check("addi_b30_op", 32'(alu_op), 32'h0);
    issue(7'b0110011, 3'b011, 1'b0, 5'd1, 5'd2, 5'd3,
          32'd9, 32'd4, 32'd0, 32'h0);
    check("sltu_op", 32'(alu_op), 32'h9);
    issue(7'b0110011, 3'b110, 1'b0, 5'd1, 5'd2, 5'd3,
          32'd9, 32'd4, 32'd0, 32'h0);
    check("or_op", 32'(alu_op), 32'h3);
    issue(7'b1100011, 3'b100, 1'b0, 5'd1, 5'd2, 5'd0,
          32'd11, 32'd12, 32'h10, 32'h0);
    check("blt_op", 32'(alu_op), 32'h8);
    check("blt_a", alu_a, 32'd11);
    check("blt_b", alu_b, 32'd12);
    check("blt_ill", 32'(illegal), 32'd0);
    issue(7'b1100011, 3'b111, 1'b0, 5'd1, 5'd2, 5'd0,
          32'd11, 32'd12, 32'h10, 32'h0);
    check("bgeu_op", 32'(alu_op), 32'h9);
    issue(7'b1100011, 3'b001, 1'b0, 5'd1, 5'd2, 5'd0,
          32'd11, 32'd12, 32'h10, 32'h0);
    check("bne_op", 32'(alu_op), 32'h1);
    issue(7'b1100011, 3'b010, 1'b0, 5'd1, 5'd2, 5'd0,
          32'd11, 32'd12, 32'h10, 32'h0);
    check("br010_ill", 32'(illegal), 32'd1);
    check("br010_op", 32'(alu_op), 32'h0);

    // Forwarding: MEM over WB, WB alone, x0 never forwarded.
    mem_fwd_valid = 1'b1;
    mem_fwd_rd    = 5'd1;
    mem_fwd_data  = 32'hAA;
    wb_fwd_valid  = 1'b1;
    wb_fwd_rd     = 5'd1;
    wb_fwd_data   = 32'hBB;
    issue(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3,
          32'h11, 32'h22, 32'd0, 32'h0);
    check("fwd_mem_a", alu_a, 32'hAA);
    check("fwd_none_b", alu_b, 32'h22);
    mem_fwd_rd = 5'd9;
    wb_fwd_rd  = 5'd2;
    issue(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3,
          32'h11, 32'h22, 32'd0, 32'h0);
    check("fwd_wb_b", alu_b, 32'hBB);
    check("fwd_wb_sd", ex_store_data, 32'hBB);
    check("fwd_rf_a", alu_a, 32'h11);
    mem_fwd_rd   = 5'd0;
    mem_fwd_data = 32'hCC;
    wb_fwd_rd    = 5'd0;
    issue(7'b0110011, 3'b000, 1'b0, 5'd0, 5'd2, 5'd3,
          32'h99, 32'h22, 32'd0, 32'h0);
    check("x0_a", alu_a, 32'd0);
    clr_fwd();

    // Stall for three cycles, forward into the held rs2, then release.
    issue(7'b0110011, 3'b000, 1'b0, 5'd4, 5'd5, 5'd6,
          32'h10, 32'h20, 32'd0, 32'h0);
    ex_ready = 1'b0;
    set_in(7'b0110011, 3'b000, 1'b0, 5'd7, 5'd8, 5'd9,
           32'd1, 32'd2, 32'd0, 32'h0);
    #1;
    check("stall_rdy", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid", 32'(ex_valid), 32'd1);
      check("stall_rd", 32'(ex_rd), 32'd6);
      check("stall_a", alu_a, 32'h10);
    end
    wb_fwd_valid = 1'b1;
    wb_fwd_rd    = 5'd5;
    wb_fwd_data  = 32'h55;
    step();
    clr_fwd();
    check("stall_fwd_b", alu_b, 32'h55);
    check("stall_fwd_a", alu_a, 32'h10);
    step();
    check("stall_keep_b", alu_b, 32'h55);
    ex_ready = 1'b1;
    #1;
    check("release_rdy", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("next_valid", 32'(ex_valid), 32'd1);
    check("next_rd", 32'(ex_rd), 32'd9);
    check("next_a", alu_a, 32'd1);

    // Flush with a pending input and a consumer ready.
    flush = 1'b1;
    set_in(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd12,
           32'd3, 32'd3, 32'd0, 32'h0);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", 32'(ex_valid), 32'd0);

    issue(7'b1111111, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3,
          32'h77, 32'h88, 32'h5, 32'h0);
    check("bad_ill", 32'(illegal), 32'd1);
    check("bad_op", 32'(alu_op), 32'h0);
    check("bad_a", alu_a, 32'd0);
    check("bad_b", alu_b, 32'd0);

    issue(7'b0110111, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3,
          32'h77, 32'h88, 32'h12345000, 32'h0);
    check("lui_a", alu_a, 32'd0);
    check("lui_b", alu_b, 32'h12345000);
    check("lui_ill", 32'(illegal), 32'd0);
    issue(7'b0010111, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3,
          32'h77, 32'h88, 32'h20, 32'h100);
    check("auipc_a", alu_a, 32'h100);
    check("auipc_b", alu_b, 32'h20);
    issue(7'b1101111, 3'b000, 1'b0, 5'd1, 5'd2, 5'd1,
          32'h77, 32'h88, 32'h800, 32'h200);
    check("jal_a", alu_a, 32'h200);
    check("jal_b", alu_b, 32'd4);
    issue(7'b0000011, 3'b010, 1'b0, 5'd1, 5'd2, 5'd3,
          32'h1000, 32'h88, 32'h8, 32'h0);
    check("lw_a", alu_a, 32'h1000);
    check("lw_b", alu_b, 32'h8);
    check("lw_op", 32'(alu_op), 32'h0);

    // Asynchronous reset in the middle of a stall.
    ex_ready = 1'b0;
    issue(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3,
          32'd5, 32'd6, 32'd0, 32'h0);
    check("pre_rst_valid", 32'(ex_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(ex_valid), 32'd0);
    check("async_rst_a", alu_a, 32'd0);
    step();
    rst_n    = 1'b1;
    ex_ready = 1'b1;
    step();
    check("post_rst_valid", 32'(ex_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
